// File: rtl/vec_pkg.sv
// -----------------------------------------------------------------------------
// vec_pkg
//   Shared definitions for the vector feeder: default vector geometry, FIFO
//   depth default, the feeder FSM state encoding and a small width helper.
//   Optional feature macro used by importers: VEC_FEEDER_ZERO_PAD_EN.
// -----------------------------------------------------------------------------
package vec_pkg;

   localparam int unsigned VEC_LEN_DEF    = 10;
   localparam int unsigned DATA_W_DEF     = 8;
   localparam int unsigned FIFO_DEPTH_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_START  = 2'd1,
      ST_STREAM = 2'd2,
      ST_PAD    = 2'd3
   } vec_state_t;

   // Counter width for a modulo-n counter; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with occupancy output. DEPTH must be a power of two so
//   the read/write pointers wrap naturally modulo DEPTH.
//
// Ports
//   clk      in   clock
//   rst      in   asynchronous active-high reset (flushes pointers/level)
//   i_push   in   write i_data this cycle (ignored when full)
//   i_data   in   DATA_W write data
//   i_pop    in   advance the read pointer this cycle (ignored when empty)
//   o_data   out  DATA_W head entry (combinational read)
//   o_level  out  $clog2(DEPTH)+1 current occupancy
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [DATA_W-1:0]        i_data,
   input  logic                     i_pop,
   output logic [DATA_W-1:0]        o_data,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_level;
   logic              w_do_push;
   logic              w_do_pop;

   assign w_do_push = i_push && (r_level != C_FULL);
   assign w_do_pop  = i_pop  && (r_level != '0);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         // Simultaneous push and pop leave the occupancy unchanged.
         if (w_do_push && !w_do_pop) begin
            r_level <= r_level + 1'b1;
         end else if (w_do_pop && !w_do_push) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_level = r_level;

endmodule

// File: rtl/vec_feeder.sv
// -----------------------------------------------------------------------------
// vec_feeder
//   Buffers upstream elements in a FIFO and, whenever the core is idle and a
//   whole vector is buffered, emits a one-cycle vec_start followed by VEC_LEN
//   consecutive registered elements on next_in/next_valid.
//
//   Optional feature: define VEC_FEEDER_ZERO_PAD_EN to zero-pad vectors that
//   are terminated early by in_last. Without it in_last is ignored.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   in_valid    in   upstream element valid
//   in_data     in   DATA_W upstream element
//   in_last     in   final element of a vector (qualified by in_valid)
//   in_ready    out  element accepted this cycle when in_valid is high
//   core_ready  in   core idle, able to take a new vector (sampled in IDLE)
//   vec_start   out  one-cycle pulse preceding a burst
//   next_in     out  DATA_W element presented to the core (0 when not valid)
//   next_valid  out  next_in valid
//   busy        out  high in START, STREAM and PAD
//   fifo_level  out  $clog2(FIFO_DEPTH)+1 FIFO occupancy
// -----------------------------------------------------------------------------
module vec_feeder
   import vec_pkg::*;
#(
   parameter int unsigned VEC_LEN    = VEC_LEN_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_last,
   output logic                          in_ready,
   input  logic                          core_ready,
   output logic                          vec_start,
   output logic [DATA_W-1:0]             next_in,
   output logic                          next_valid,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CW = cnt_width(VEC_LEN);

   localparam logic [LW-1:0] C_LVL_VEC  = LW'(VEC_LEN);
   localparam logic [LW-1:0] C_LVL_FULL = LW'(FIFO_DEPTH);
   localparam logic [CW-1:0] C_LAST_IDX = CW'(VEC_LEN - 1);

   vec_state_t        r_state;
   vec_state_t        w_state_nxt;
   logic [CW-1:0]     r_elem_cnt;
   logic [CW-1:0]     r_pop_cnt;
   logic [LW-1:0]     w_level;
   logic [DATA_W-1:0] w_fifo_dout;
   logic [DATA_W-1:0] w_fifo_din;
   logic [DATA_W-1:0] r_next_in;
   logic              r_next_valid;
   logic              w_in_ready;
   logic              w_push_up;
   logic              w_fifo_push;
   logic              w_pop;
   logic              w_early_last;
   logic              w_pad_entry;
   logic              w_pad_push;
   logic              w_pad_done;

   assign w_push_up = in_valid && w_in_ready;

`ifdef VEC_FEEDER_ZERO_PAD_EN
   logic              r_pad_pend;
   logic [CW-1:0]     r_pad_cnt;

   assign w_early_last = w_push_up && in_last && (r_elem_cnt != C_LAST_IDX);
   assign w_pad_entry  = r_pad_pend || w_early_last;
   assign w_pad_push   = (r_state == ST_PAD) && (w_level != C_LVL_FULL);
   assign w_pad_done   = w_pad_push && (r_pad_cnt == CW'(1));

   // An early in_last seen during START/STREAM is remembered and padded once
   // the burst finishes; upstream is held off meanwhile so the zeros land
   // directly behind the short vector.
   assign w_in_ready = !reset && (w_level != C_LVL_FULL) &&
                       (r_state != ST_PAD) && !r_pad_pend;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pad_pend <= 1'b0;
         r_pad_cnt  <= '0;
      end else begin
         if (r_state == ST_IDLE) begin
            r_pad_pend <= 1'b0;
         end else if (w_early_last) begin
            r_pad_pend <= 1'b1;
         end

         if (w_early_last) begin
            r_pad_cnt <= C_LAST_IDX - r_elem_cnt;
         end else if (w_pad_push) begin
            r_pad_cnt <= r_pad_cnt - 1'b1;
         end
      end
   end
`else
   logic w_unused;

   assign w_unused     = in_last;
   assign w_early_last = 1'b0;
   assign w_pad_entry  = 1'b0;
   assign w_pad_push   = 1'b0;
   assign w_pad_done   = 1'b0;
   assign w_in_ready   = !reset && (w_level != C_LVL_FULL) && (r_state != ST_PAD);
`endif

   assign w_fifo_push = w_push_up || w_pad_push;
   assign w_fifo_din  = w_pad_push ? '0 : in_data;

   // Because next_in is registered, the pop that feeds the first element
   // happens in START and the final STREAM cycle pops nothing; next_valid is
   // thus high for exactly the VEC_LEN STREAM cycles.
   assign w_pop = (r_state == ST_START) ||
                  ((r_state == ST_STREAM) && (r_pop_cnt != C_LAST_IDX));

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (w_fifo_push),
      .i_data  (w_fifo_din),
      .i_pop   (w_pop),
      .o_data  (w_fifo_dout),
      .o_level (w_level)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            // Padding wins over starting a burst in the same cycle.
            if (w_pad_entry) begin
               w_state_nxt = ST_PAD;
            end else if (core_ready && (w_level >= C_LVL_VEC)) begin
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            w_state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            if (r_pop_cnt == C_LAST_IDX) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_PAD: begin
            if (w_pad_done) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pop_cnt <= '0;
      end else if (r_state == ST_STREAM) begin
         r_pop_cnt <= r_pop_cnt + 1'b1;
      end else begin
         r_pop_cnt <= '0;
      end
   end

   // Position inside the vector being pushed; an early in_last (pad build
   // only) restarts it because the remainder of the vector is zero-filled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_elem_cnt <= '0;
      end else if (w_push_up) begin
         if (w_early_last || (r_elem_cnt == C_LAST_IDX)) begin
            r_elem_cnt <= '0;
         end else begin
            r_elem_cnt <= r_elem_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_next_valid <= 1'b0;
         r_next_in    <= '0;
      end else begin
         r_next_valid <= w_pop;
         r_next_in    <= w_pop ? w_fifo_dout : '0;
      end
   end

   assign in_ready   = w_in_ready;
   assign vec_start  = (r_state == ST_START);
   assign next_valid = r_next_valid;
   assign next_in    = r_next_in;
   assign busy       = (r_state != ST_IDLE);
   assign fifo_level = w_level;

endmodule

// File: tb/tb_vec_feeder.sv
module tb_vec_feeder;

   localparam int unsigned VEC_LEN    = 10;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned FIFO_DEPTH = 16;
   localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_ready;
   logic              core_ready;
   logic              vec_start;
   logic [DATA_W-1:0] next_in;
   logic              next_valid;
   logic              busy;
   logic [LW-1:0]     fifo_level;

   int n_tests = 0;
   int n_fail  = 0;
   int vs_cnt  = 0;
   int run_len = 0;
   logic prev_vs = 1'b0;
   logic [DATA_W-1:0] exp_q [$];

   vec_feeder #(
      .VEC_LEN    (VEC_LEN),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .core_ready (core_ready),
      .vec_start  (vec_start),
      .next_in    (next_in),
      .next_valid (next_valid),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: compares every presented element with the queue head.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         run_len = 0;
         prev_vs = 1'b0;
      end else begin
         if (prev_vs) chk("first_after_vs", {31'd0, next_valid}, 32'd1);
         if (vec_start) begin
            vs_cnt++;
            chk("vs_no_valid", {31'd0, next_valid}, 32'd0);
         end
         if (next_valid) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_elem: got %0d expected none at %0t", next_in, $time);
            end else begin
               chk("data", {24'd0, next_in}, {24'd0, exp_q.pop_front()});
            end
            run_len++;
         end else begin
            chk("idle_zero", {24'd0, next_in}, 32'd0);
            if (run_len != 0) begin
               chk("burst_len", run_len, VEC_LEN);
               run_len = 0;
            end
         end
         prev_vs = vec_start;
      end
   end

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic push(input logic [DATA_W-1:0] d, input logic last);
      int b;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      b = 0;
      while (!in_ready && b < 200) begin
         @(posedge clk); #1;
         b++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL push_timeout: got in_ready 0 expected 1 for data %0d", d);
      end else begin
         @(posedge clk); #1;
         exp_q.push_back(d);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_idle(input int bursts);
      int b;
      b = 0;
      while (!(vs_cnt >= bursts && !busy) && b < 300) begin
         @(posedge clk); #1;
         b++;
      end
      chk("wait_bursts", vs_cnt, bursts);
      chk("wait_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int lvl_prev;
      int b;
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      in_last    = 1'b0;
      core_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_level", {27'd0, fifo_level}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, next_valid}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Single vector 1..10
      core_ready = 1'b1;
      for (int i = 1; i <= 10; i++) push(i[DATA_W-1:0], i == 10);
      chk("t1_vs_pre", {31'd0, vec_start}, 32'd0);
      @(posedge clk); #1;
      chk("t1_vs_lat", {31'd0, vec_start}, 32'd1);
      wait_idle(1);
      chk("t1_level", {27'd0, fifo_level}, 32'd0);

      // Fill to 16 while the core is busy
      core_ready = 1'b0;
      for (int i = 20; i < 36; i++) push(i[DATA_W-1:0], 1'b0);
      chk("t2_level16", {27'd0, fifo_level}, 32'd16);
      chk("t2_full_ready", {31'd0, in_ready}, 32'd0);
      chk("t2_no_burst", vs_cnt, 1);
      core_ready = 1'b1;
      wait_idle(2);
      chk("t2_level6", {27'd0, fifo_level}, 32'd6);
      for (int i = 36; i < 40; i++) push(i[DATA_W-1:0], 1'b0);
      wait_idle(3);
      chk("t2_drained", {27'd0, fifo_level}, 32'd0);

      // Back-to-back pushes through a burst
      lvl_prev = 0;
      for (int i = 0; i < 20; i++) begin
         push(8'(50 + i), 1'b0);
         if (i >= 12) chk("t3_level_flat", {27'd0, fifo_level}, lvl_prev);
         lvl_prev = int'(fifo_level);
      end
      wait_idle(5);
      chk("t3_drained", {27'd0, fifo_level}, 32'd0);
      chk("t3_sb_empty", exp_q.size(), 0);

      // Short vector 7,8,9 with in_last on 9
      push(8'd7, 1'b0);
      push(8'd8, 1'b0);
      push(8'd9, 1'b1);
`ifdef VEC_FEEDER_ZERO_PAD_EN
      for (int i = 0; i < 7; i++) exp_q.push_back('0);
      wait_idle(6);
      chk("t4_pad_level", {27'd0, fifo_level}, 32'd0);
`else
      repeat (20) @(posedge clk);
      #1;
      chk("t4_no_burst", vs_cnt, 5);
      chk("t4_level3", {27'd0, fifo_level}, 32'd3);
      for (int i = 10; i <= 16; i++) push(i[DATA_W-1:0], 1'b0);
      wait_idle(6);
      chk("t4_level0", {27'd0, fifo_level}, 32'd0);
`endif

      // Reset in the middle of a burst
      for (int i = 0; i < 10; i++) push(8'(100 + i), 1'b0);
      b = 0;
      while (run_len != 3 && b < 100) begin
         @(negedge clk);
         b++;
      end
      chk("t5_reach_elem3", run_len, 3);
      @(posedge clk); #2;
      chk("t5_pre_valid", {31'd0, next_valid}, 32'd1);
      reset = 1'b1;
      #1;
      chk("t5_valid", {31'd0, next_valid}, 32'd0);
      chk("t5_vs", {31'd0, vec_start}, 32'd0);
      chk("t5_data", {24'd0, next_in}, 32'd0);
      chk("t5_level", {27'd0, fifo_level}, 32'd0);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) push(8'(200 + i), 1'b0);
      wait_idle(8);
      chk("t5_after_level", {27'd0, fifo_level}, 32'd0);
      chk("t5_sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
